vedic_mul_pipe: RTL and testbench
=================================

VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; even, >= 4.
REQ-002 SHALL have parameter ACC_W, default 2*WIDTH+8, accumulator width; >= 2*WIDTH+1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand transaction offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the offered transaction.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port acc_en  input  1  add this product into the accumulator.
REQ-011 SHALL have port acc_clr  input  1  zero the accumulator before this transaction's add.
REQ-012 SHALL have port out_valid  output  1  product p valid.
REQ-013 SHALL have port out_ready  input  1  downstream consumes p.
REQ-014 SHALL have port p  output  2*WIDTH  product (unsigned or two's-complement per its tag).
REQ-015 SHALL have port acc  output  ACC_W  signed running accumulator.
REQ-016 SHALL have port acc_ovf  output  1  sticky accumulator signed-overflow flag.

Function
REQ-017 SHALL accept a transaction on a rising edge where in_valid && in_ready; a, b, is_signed, acc_en and acc_clr are sampled together as one transaction.
REQ-018 Stage 1 SHALL register sign (signed mode: sign(a) XOR sign(b); unsigned: 0), all tags, and the four half-width Vedic partial products of |a|,|b|: LL, LH, HL, HH.
REQ-019 Magnitude of the most negative operand (-2^(WIDTH-1)) SHALL be 2^(WIDTH-1), held in WIDTH unsigned bits without error.
REQ-020 Stage 2 SHALL register p = HH<<WIDTH + (LH+HL)<<(WIDTH/2) + LL, negated when sign=1, exact in 2*WIDTH bits.
REQ-021 Latency SHALL be 2 cycles: a transaction accepted at edge N, with no stall, shows out_valid=1 and its p after edge N+1.
REQ-022 Stall control SHALL be: en2 = !out_valid || out_ready; en1 = !s1_valid || en2; in_ready = en1 (combinational from out_ready).
REQ-023 p, out_valid and its tags SHALL hold stable while out_valid && !out_ready.
REQ-024 Capacity SHALL be 2 transactions; sustained throughput 1 per cycle when out_ready=1.
REQ-025 Accumulator SHALL update only on an output handshake (out_valid && out_ready): base = acc_clr ? 0 : acc; acc = acc_en ? base + ext(p) : base.
REQ-026 ext(p) SHALL sign-extend p when its is_signed tag=1, else zero-extend, to ACC_W.
REQ-027 acc_ovf SHALL set when that add overflows signed ACC_W range; remains set until a handshake with acc_clr=1 whose own add does not overflow.
REQ-028 No transaction SHALL be dropped, duplicated or reordered; in_valid with in_ready=0 has no effect.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear out_valid, stage-1 valid, p, acc, acc_ovf and tags to 0; in-flight transactions are discarded.
REQ-030 While rst_n=0 in_ready SHALL be 0; first acceptance is at the first rising edge with rst_n=1.

Verification
REQ-031 Unsigned WIDTH=16: (5,10),(43210,12345),(65535,65535) back-to-back, out_ready=1 -> p = 50, 533427450, 0xFFFE0001 on consecutive cycles, first 2 cycles after accept.
REQ-032 Signed: (0xFFFF,0xFFFF) -> 0x00000001; (0x8000,0x8000) -> 0x40000000; (0x8000,0x0001) -> 0xFFFF8000; (0,12345) -> 0.
REQ-033 Accumulate: (5,10,acc_clr=1,acc_en=1) then (123,456,acc_en=1) then (255,255,acc_en=0) -> acc = 50, 56138, 56138.
REQ-034 Backpressure: out_ready=0, offer 3 transactions -> first two accepted, in_ready=0 for third; p frozen; release out_ready -> all three delivered in order.
REQ-035 Overflow/reset: WIDTH=4, ACC_W=9, signed (0x8,0x8)=64 accumulated 4x -> acc_ovf=1; rst_n pulse with 1 in flight -> out_valid=0, acc=0, acc_ovf=0, nothing delivered.

Source files
------------

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe
//   Two-stage pipelined multiplier with a signed running accumulator.
//   Stage 1 takes operand magnitudes and forms the four half-width
//   (Vedic "vertically and crosswise") partial products. Stage 2 combines
//   them into the full product and restores the sign. An output handshake
//   optionally adds the product into the accumulator.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction offered
//   in_ready   transaction accepted this cycle (combinational from out_ready)
//   a, b       operands, WIDTH bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   acc_en     add this product into the accumulator on its output handshake
//   acc_clr    zero the accumulator before this transaction's add
//   out_valid  p valid
//   out_ready  downstream consumes p
//   p          product, 2*WIDTH bits
//   acc        signed running accumulator, ACC_W bits
//   acc_ovf    sticky signed-overflow flag of the accumulator
module vedic_mul_pipe #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 2 * WIDTH + 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic [ACC_W-1:0]   acc,
    output logic               acc_ovf
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    // stage-1 registers
    logic             s1_valid;
    logic             s1_sign;
    logic             s1_signed;
    logic             s1_acc_en;
    logic             s1_acc_clr;
    logic [WIDTH-1:0] s1_ll, s1_lh, s1_hl, s1_hh;

    // output-stage tags
    logic             out_signed;
    logic             out_acc_en;
    logic             out_acc_clr;

    logic en1, en2;
    logic out_hs;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = rst_n && en1;
    assign out_hs   = out_valid && out_ready;

    // Magnitudes. Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1), which
    // is exactly the magnitude when the WIDTH bits are read as unsigned.
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sign_d;
    logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;

    always_comb begin
        mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
        sign_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        ll_d   = WIDTH'(mag_a[H-1:0])     * WIDTH'(mag_b[H-1:0]);
        lh_d   = WIDTH'(mag_a[H-1:0])     * WIDTH'(mag_b[WIDTH-1:H]);
        hl_d   = WIDTH'(mag_a[WIDTH-1:H]) * WIDTH'(mag_b[H-1:0]);
        hh_d   = WIDTH'(mag_a[WIDTH-1:H]) * WIDTH'(mag_b[WIDTH-1:H]);
    end

    // Recombination; the magnitude never exceeds 2^(2*WIDTH)-1 so PW bits
    // are exact for both modes.
    logic [PW-1:0] cross_sum, mag_p, p_next;

    always_comb begin
        cross_sum = PW'(s1_lh) + PW'(s1_hl);
        mag_p     = (PW'(s1_hh) << WIDTH) + (cross_sum << H) + PW'(s1_ll);
        p_next    = s1_sign ? -mag_p : mag_p;
    end

    // Accumulator update path, evaluated against the product at the output.
    logic [ACC_W-1:0] acc_base, p_ext, acc_sum, acc_next;
    logic             add_ovf, ovf_next;

    always_comb begin
        acc_base = out_acc_clr ? '0 : acc;
        p_ext    = {{(ACC_W-PW){out_signed & p[PW-1]}}, p};
        acc_sum  = acc_base + p_ext;
        add_ovf  = out_acc_en
                   && (acc_base[ACC_W-1] == p_ext[ACC_W-1])
                   && (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
        acc_next = out_acc_en ? acc_sum : acc_base;
        // a clearing handshake drops the old flag; only its own add can set it
        ovf_next = (out_acc_clr ? 1'b0 : acc_ovf) | add_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_signed  <= 1'b0;
            s1_acc_en  <= 1'b0;
            s1_acc_clr <= 1'b0;
            s1_ll      <= '0;
            s1_lh      <= '0;
            s1_hl      <= '0;
            s1_hh      <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= sign_d;
                s1_signed  <= is_signed;
                s1_acc_en  <= acc_en;
                s1_acc_clr <= acc_clr;
                s1_ll      <= ll_d;
                s1_lh      <= lh_d;
                s1_hl      <= hl_d;
                s1_hh      <= hh_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            p           <= '0;
            out_signed  <= 1'b0;
            out_acc_en  <= 1'b0;
            out_acc_clr <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                p           <= p_next;
                out_signed  <= s1_signed;
                out_acc_en  <= s1_acc_en;
                out_acc_clr <= s1_acc_clr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (out_hs) begin
            acc     <= acc_next;
            acc_ovf <= ovf_next;
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb_vedic_mul_pipe
//   Directed bench for vedic_mul_pipe: a WIDTH=16 instance for products,
//   latency, accumulation and backpressure, and a WIDTH=4/ACC_W=9 instance
//   for accumulator overflow and reset with a transaction in flight.
module tb_vedic_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        rst_n16;
    logic        v16, rdy16, s16, en16, clr16, ov16, ordy16, ovf16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic [39:0] acc16;

    vedic_mul_pipe #(.WIDTH(16), .ACC_W(40)) u_dut16 (
        .clk(clk), .rst_n(rst_n16), .in_valid(v16), .in_ready(rdy16),
        .a(a16), .b(b16), .is_signed(s16), .acc_en(en16), .acc_clr(clr16),
        .out_valid(ov16), .out_ready(ordy16), .p(p16), .acc(acc16),
        .acc_ovf(ovf16)
    );

    // WIDTH=4 instance
    logic       rst_n4;
    logic       v4, rdy4, s4, en4, clr4, ov4, ordy4, ovf4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic [8:0] acc4;

    vedic_mul_pipe #(.WIDTH(4), .ACC_W(9)) u_dut4 (
        .clk(clk), .rst_n(rst_n4), .in_valid(v4), .in_ready(rdy4),
        .a(a4), .b(b4), .is_signed(s4), .acc_en(en4), .acc_clr(clr4),
        .out_valid(ov4), .out_ready(ordy4), .p(p4), .acc(acc4),
        .acc_ovf(ovf4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive16(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic ts, input logic ten, input logic tclr);
        v16 = v; a16 = ta; b16 = tb_; s16 = ts; en16 = ten; clr16 = tclr;
    endtask

    // one isolated transaction on the small instance, waits through its handshake
    task automatic send4(input logic [3:0] ta, input logic [3:0] tb_,
                         input logic ts, input logic ten, input logic tclr,
                         input logic [7:0] exp_p);
        a4 = ta; b4 = tb_; s4 = ts; en4 = ten; clr4 = tclr; v4 = 1'b1;
        chk("in_ready4", rdy4, 1);
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("out_valid4", ov4, 1);
        chk("p4", p4, exp_p);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] exp_p;
    } vec_t;

    vec_t vecs[9];
    int   delivered;

    initial begin
        vecs[0] = '{16'd5,     16'd10,    1'b0, 32'd50};
        vecs[1] = '{16'd43210, 16'd12345, 1'b0, 32'd533427450};
        vecs[2] = '{16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE0001};
        vecs[3] = '{16'hFFFF,  16'hFFFF,  1'b1, 32'h00000001};
        vecs[4] = '{16'h8000,  16'h8000,  1'b1, 32'h40000000};
        vecs[5] = '{16'h8000,  16'h0001,  1'b1, 32'hFFFF8000};
        vecs[6] = '{16'h0000,  16'd12345, 1'b1, 32'h00000000};
        vecs[7] = '{16'h0003,  16'hFFFE,  1'b1, 32'hFFFFFFFA};
        vecs[8] = '{16'h8000,  16'h0002,  1'b0, 32'h00010000};

        rst_n16 = 1'b0; rst_n4 = 1'b0;
        ordy16 = 1'b1; ordy4 = 1'b1;
        drive16(1'b1, 16'd7, 16'd7, 1'b0, 1'b1, 1'b0);
        v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; en4 = 1'b0; clr4 = 1'b0;

        // reset state, with a transaction offered throughout
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", rdy16, 0);
        chk("rst out_valid", ov16, 0);
        chk("rst p", p16, 0);
        chk("rst acc", acc16, 0);
        chk("rst acc_ovf", ovf16, 0);
        drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        rst_n16 = 1'b1; rst_n4 = 1'b1;
        #1;
        chk("idle in_ready", rdy16, 1);
        @(posedge clk); #1;
        chk("no phantom txn", ov16, 0);

        // back-to-back vector table, result visible the edge after the accepting one
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) begin
                drive16(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, 1'b0);
                chk("tbl in_ready", rdy16, 1);
            end else begin
                drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                chk($sformatf("tbl out_valid[%0d]", i-1), ov16, 1);
                chk($sformatf("tbl p[%0d]", i-1), p16, vecs[i-1].exp_p);
            end
        end
        @(posedge clk); #1;
        chk("tbl drained", ov16, 0);
        chk("tbl acc untouched", acc16, 0);

        // accumulate sequence, acc updates on each output handshake
        drive16(1'b1, 16'd5, 16'd10, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive16(1'b1, 16'd123, 16'd456, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive16(1'b1, 16'd255, 16'd255, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("acc 1", acc16, 40'd50);
        drive16(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("acc 2", acc16, 40'd56138);
        drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("acc 3", acc16, 40'd56138);
        @(posedge clk); #1;
        chk("acc signed add", acc16, 40'd56137);
        chk("acc no ovf", ovf16, 0);
        @(posedge clk); #1;

        // backpressure: two accepted, third held off, p frozen, then in-order drain
        ordy16 = 1'b0;
        drive16(1'b1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
        chk("bp in_ready t0", rdy16, 1);
        @(posedge clk); #1;
        drive16(1'b1, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0);
        chk("bp in_ready t1", rdy16, 1);
        @(posedge clk); #1;
        drive16(1'b1, 16'd5, 16'd6, 1'b0, 1'b0, 1'b0);
        chk("bp out_valid", ov16, 1);
        chk("bp p t0", p16, 2);
        chk("bp in_ready t2", rdy16, 0);
        @(posedge clk); #1;
        chk("bp hold valid", ov16, 1);
        chk("bp hold p", p16, 2);
        chk("bp hold in_ready", rdy16, 0);
        ordy16 = 1'b1;
        #1;
        chk("bp release in_ready", rdy16, 1);
        @(posedge clk); #1;
        drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        chk("bp p t1", p16, 12);
        @(posedge clk); #1;
        chk("bp p t2 valid", ov16, 1);
        chk("bp p t2", p16, 30);
        @(posedge clk); #1;
        chk("bp drained", ov16, 0);

        // small instance: signed -8 * -8 = 64, four times overflows 9-bit range
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b1, 8'd64);
        chk("ovf acc 1", acc4, 9'd64);
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        chk("ovf acc 2", acc4, 9'd128);
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        chk("ovf acc 3", acc4, 9'd192);
        chk("ovf not yet", ovf4, 0);
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        chk("ovf acc 4", acc4, 9'h100);
        chk("ovf set", ovf4, 1);
        send4(4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 8'd1);
        chk("ovf sticky acc", acc4, 9'h101);
        chk("ovf sticky", ovf4, 1);

        // reset with one transaction in flight
        a4 = 4'h8; b4 = 4'h8; s4 = 1'b1; en4 = 1'b1; clr4 = 1'b0; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        rst_n4 = 1'b0;
        #1;
        chk("rst4 out_valid", ov4, 0);
        chk("rst4 acc", acc4, 0);
        chk("rst4 acc_ovf", ovf4, 0);
        chk("rst4 in_ready", rdy4, 0);
        #2;
        rst_n4 = 1'b1;
        delivered = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ov4) delivered++;
        end
        chk("rst4 nothing delivered", delivered, 0);
        chk("rst4 acc after", acc4, 0);

        // overflow again, then a clearing handshake with no add drops the flag
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        send4(4'h8, 4'h8, 1'b1, 1'b1, 1'b0, 8'd64);
        chk("ovf2 set", ovf4, 1);
        send4(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0);
        chk("clr acc", acc4, 0);
        chk("clr ovf", ovf4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
